// File: rtl/branch_resolve_queue_pkg.sv
// Shared branch-resolution definitions: mask width, mask type and the complete-stage report packet.
package sys_defs;

    localparam int unsigned B_MASK_WIDTH = 4;
    localparam int unsigned NUM_BR_UNITS = 2;
    localparam int unsigned B_CNT_WIDTH  = $clog2(B_MASK_WIDTH) + 1;

    typedef logic [B_MASK_WIDTH-1:0] B_MASK;

    typedef struct packed {
        logic  valid;
        B_MASK b_mm;
        B_MASK b_mask;
        logic  mispred;
    } BR_RESOLVE_PACKET;

    // Isolates the lowest set bit (two's-complement trick); zero in, zero out.
    function automatic B_MASK lowest_bit(B_MASK m);
        B_MASK neg;
        neg = ~m + B_MASK'(1);
        return m & neg;
    endfunction

endpackage

// File: rtl/branch_resolve_queue_if.sv
// Report bus from the complete stage and resolve bus toward the branch stack.
interface branch_resolve_queue_if;
    import sys_defs::*;

    logic [NUM_BR_UNITS-1:0] br_valid;
    B_MASK [NUM_BR_UNITS-1:0] br_b_mm;
    B_MASK [NUM_BR_UNITS-1:0] br_b_mask;
    logic [NUM_BR_UNITS-1:0] br_mispred;
    B_MASK                   b_mm_resolve;
    logic                    b_mm_mispred;
    B_MASK                   pending_mask;
    logic [B_CNT_WIDTH-1:0]  pending_count;

    modport master (
        output br_valid, br_b_mm, br_b_mask, br_mispred,
        input  b_mm_resolve, b_mm_mispred, pending_mask, pending_count
    );

    modport slave (
        input  br_valid, br_b_mm, br_b_mask, br_mispred,
        output b_mm_resolve, b_mm_mispred, pending_mask, pending_count
    );

endinterface

// File: rtl/branch_resolve_queue_select.sv
// Picks one slot to resolve: oldest mispredict first (lowest index), else lowest valid slot.
module br_resolve_select
    import sys_defs::*;
(
    input  B_MASK                    valid,
    input  B_MASK                    mispred,
    input  B_MASK [B_MASK_WIDTH-1:0] dep,
    output B_MASK                    issue,
    output logic                     issue_mispred
);

    B_MASK vm;
    B_MASK cand;

    always_comb begin
        vm   = valid & mispred;
        cand = '0;
        // A mispredict is oldest when it depends on no other pending mispredict.
        for (int i = 0; i < B_MASK_WIDTH; i++) begin
            cand[i] = vm[i] && ((dep[i] & vm) == '0);
        end
        if (cand != '0) begin
            issue         = lowest_bit(cand);
            issue_mispred = 1'b1;
        end else begin
            issue         = lowest_bit(valid);
            issue_mispred = 1'b0;
        end
    end

endmodule

// File: rtl/branch_resolve_queue.sv
// One slot per branch-mask bit; releases one resolution per cycle, scrubbing and squashing deps.
module branch_resolve_queue
    import sys_defs::*;
(
    input logic                    clock,
    input logic                    reset,
    branch_resolve_queue_if.slave  bus
);

    B_MASK                    valid_q, valid_d;
    B_MASK                    mispred_q, mispred_d;
    B_MASK [B_MASK_WIDTH-1:0] dep_q, dep_d;
    B_MASK                    issue;
    logic                     issue_mispred;
    logic [B_CNT_WIDTH-1:0]   count;

    br_resolve_select u_select (
        .valid         (valid_q),
        .mispred       (mispred_q),
        .dep           (dep_q),
        .issue         (issue),
        .issue_mispred (issue_mispred)
    );

    always_comb begin
        valid_d   = valid_q & ~issue;
        mispred_d = mispred_q;
        dep_d     = dep_q;
        for (int j = 0; j < B_MASK_WIDTH; j++) begin
            dep_d[j] = dep_q[j] & ~issue;
            if (issue_mispred && ((dep_q[j] & issue) != '0)) begin
                valid_d[j] = 1'b0;
            end
        end
        // Incoming writes come last so a recycled bit overrides its own issue/squash clear.
        for (int u = 0; u < NUM_BR_UNITS; u++) begin
            if (bus.br_valid[u] && !(issue_mispred && ((bus.br_b_mask[u] & issue) != '0))) begin
                for (int i = 0; i < B_MASK_WIDTH; i++) begin
                    if (bus.br_b_mm[u][i]) begin
                        valid_d[i]   = 1'b1;
                        mispred_d[i] = bus.br_mispred[u];
                        dep_d[i]     = bus.br_b_mask[u] & ~issue;
                    end
                end
            end
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            valid_q   <= '0;
            mispred_q <= '0;
            dep_q     <= '0;
        end else begin
            valid_q   <= valid_d;
            mispred_q <= mispred_d;
            dep_q     <= dep_d;
        end
    end

    always_comb begin
        count = '0;
        for (int i = 0; i < B_MASK_WIDTH; i++) begin
            count = count + B_CNT_WIDTH'(valid_q[i]);
        end
    end

    assign bus.b_mm_resolve  = issue;
    assign bus.b_mm_mispred  = issue_mispred;
    assign bus.pending_mask  = valid_q;
    assign bus.pending_count = count;

    for (genvar u = 0; u < NUM_BR_UNITS; u++) begin : g_sva
        a_onehot: assert property (@(posedge clock) disable iff (!reset)
            bus.br_valid[u] |-> $onehot(bus.br_b_mm[u]));
        a_self_dep: assert property (@(posedge clock) disable iff (!reset)
            bus.br_valid[u] |-> ((bus.br_b_mask[u] & bus.br_b_mm[u]) == '0));
        a_overwrite: assert property (@(posedge clock) disable iff (!reset)
            bus.br_valid[u] |-> ((bus.br_b_mm[u] & valid_q & ~issue) == '0));
        for (genvar v = u + 1; v < NUM_BR_UNITS; v++) begin : g_pair
            a_dup: assert property (@(posedge clock) disable iff (!reset)
                (bus.br_valid[u] && bus.br_valid[v]) |-> (bus.br_b_mm[u] != bus.br_b_mm[v]));
        end
    end

endmodule

// File: tb/tb_branch_resolve_queue.sv
// Directed plus randomized bench for branch_resolve_queue against a slot-array reference model.
module tb_branch_resolve_queue;
    import sys_defs::*;

    logic clock = 1'b0;
    logic reset = 1'b0;
    always #5 clock = ~clock;

    branch_resolve_queue_if bus ();

    branch_resolve_queue dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    int checks = 0;
    int errors = 0;

    bit    m_valid [B_MASK_WIDTH];
    bit    m_mis   [B_MASK_WIDTH];
    B_MASK m_dep   [B_MASK_WIDTH];

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] req);
        checks++;
        if (got !== req) begin
            errors++;
            $display("FAIL %s: got %0h required %0h at %0t", name, got, req, $time);
        end
    endtask

    function automatic void model_clear();
        for (int i = 0; i < B_MASK_WIDTH; i++) begin
            m_valid[i] = 1'b0;
            m_mis[i]   = 1'b0;
            m_dep[i]   = '0;
        end
    endfunction

    function automatic int slot_of(input B_MASK m);
        for (int i = 0; i < B_MASK_WIDTH; i++) if (m[i]) return i;
        return -1;
    endfunction

    // Oldest mispredict = pending mispredict not waiting on another pending mispredict.
    function automatic void model_select(output int slot, output bit mis);
        bit older;
        slot = -1;
        mis  = 1'b0;
        for (int i = 0; i < B_MASK_WIDTH; i++) begin
            if (m_valid[i] && m_mis[i]) begin
                older = 1'b0;
                for (int j = 0; j < B_MASK_WIDTH; j++)
                    if (m_valid[j] && m_mis[j] && m_dep[i][j]) older = 1'b1;
                if (!older) begin
                    slot = i;
                    mis  = 1'b1;
                    return;
                end
            end
        end
        for (int i = 0; i < B_MASK_WIDTH; i++) begin
            if (m_valid[i]) begin
                slot = i;
                return;
            end
        end
    endfunction

    function automatic void model_update(input int s, input bit mis, input logic [1:0] v,
                                         input B_MASK mm0, input B_MASK mm1,
                                         input B_MASK bm0, input B_MASK bm1,
                                         input logic [1:0] mp);
        B_MASK mm [2];
        B_MASK bm [2];
        int    k;
        mm[0] = mm0; mm[1] = mm1; bm[0] = bm0; bm[1] = bm1;
        if (s >= 0) begin
            for (int j = 0; j < B_MASK_WIDTH; j++) begin
                if (mis && m_dep[j][s]) m_valid[j] = 1'b0;
                m_dep[j][s] = 1'b0;
            end
            m_valid[s] = 1'b0;
        end
        for (int u = 0; u < 2; u++) begin
            if (v[u] && !(s >= 0 && mis && bm[u][s])) begin
                k = slot_of(mm[u]);
                m_valid[k] = 1'b1;
                m_mis[k]   = mp[u];
                m_dep[k]   = bm[u];
                if (s >= 0) m_dep[k][s] = 1'b0;
            end
        end
    endfunction

    task automatic compare_all(output int s, output bit mis);
        logic [31:0] res, msk, cnt;
        model_select(s, mis);
        res = (s < 0) ? 32'd0 : (32'd1 << s);
        msk = '0;
        cnt = '0;
        for (int i = 0; i < B_MASK_WIDTH; i++) begin
            msk[i] = m_valid[i];
            cnt    = cnt + 32'(m_valid[i]);
        end
        chk("b_mm_resolve", 32'(bus.b_mm_resolve), res);
        if (s >= 0) chk("b_mm_mispred", 32'(bus.b_mm_mispred), 32'(mis));
        chk("pending_mask", 32'(bus.pending_mask), msk);
        chk("pending_count", 32'(bus.pending_count), cnt);
    endtask

    // Called at a falling edge; returns at the next falling edge with inputs idle.
    task automatic step(input logic [1:0] v, input B_MASK mm0, input B_MASK mm1,
                        input B_MASK bm0, input B_MASK bm1, input logic [1:0] mp);
        int s;
        bit mis;
        compare_all(s, mis);
        bus.br_valid     = v;
        bus.br_b_mm[0]   = mm0;
        bus.br_b_mm[1]   = mm1;
        bus.br_b_mask[0] = bm0;
        bus.br_b_mask[1] = bm1;
        bus.br_mispred   = mp;
        @(posedge clock);
        model_update(s, mis, v, mm0, mm1, bm0, bm1, mp);
        @(negedge clock);
        bus.br_valid = '0;
    endtask

    task automatic random_step();
        int    s, k;
        bit    mis;
        B_MASK freem;
        B_MASK mm [2];
        B_MASK bm [2];
        logic [1:0] v, mp;
        model_select(s, mis);
        freem = '0;
        for (int i = 0; i < B_MASK_WIDTH; i++) freem[i] = !m_valid[i] || (i == s);
        v = '0; mp = '0;
        for (int u = 0; u < 2; u++) begin
            mm[u] = '0;
            bm[u] = '0;
            if ($urandom_range(0, 2) != 0) begin
                for (int t = 0; t < 8 && !v[u]; t++) begin
                    k = $urandom_range(0, B_MASK_WIDTH - 1);
                    if (freem[k]) begin
                        v[u]     = 1'b1;
                        mm[u]    = B_MASK'(1) << k;
                        freem[k] = 1'b0;
                        bm[u]    = B_MASK'($urandom) & ~mm[u];
                        mp[u]    = ($urandom_range(0, 2) == 0);
                    end
                end
            end
        end
        step(v, mm[0], mm[1], bm[0], bm[1], mp);
    endtask

    initial begin
        model_clear();
        bus.br_valid   = '0;
        bus.br_b_mm    = '0;
        bus.br_b_mask  = '0;
        bus.br_mispred = '0;
        repeat (2) @(negedge clock);
        chk("reset resolve", 32'(bus.b_mm_resolve), 32'd0);
        chk("reset mispred", 32'(bus.b_mm_mispred), 32'd0);
        chk("reset pending_mask", 32'(bus.pending_mask), 32'd0);
        chk("reset pending_count", 32'(bus.pending_count), 32'd0);
        reset = 1'b1;
        @(negedge clock);

        // Single correct branch.
        step(2'b01, 4'b0100, 4'b0000, 4'b0000, 4'b0000, 2'b00);
        chk("single resolve", 32'(bus.b_mm_resolve), 32'h4);
        chk("single mispred", 32'(bus.b_mm_mispred), 32'd0);
        step(2'b00, 4'b0, 4'b0, 4'b0, 4'b0, 2'b00);
        chk("single drained", 32'(bus.b_mm_resolve), 32'd0);
        chk("single count", 32'(bus.pending_count), 32'd0);

        // Two simultaneous correct reports.
        step(2'b11, 4'b0001, 4'b0100, 4'b0000, 4'b0000, 2'b00);
        chk("two first", 32'(bus.b_mm_resolve), 32'h1);
        step(2'b00, 4'b0, 4'b0, 4'b0, 4'b0, 2'b00);
        chk("two second", 32'(bus.b_mm_resolve), 32'h4);
        step(2'b00, 4'b0, 4'b0, 4'b0, 4'b0, 2'b00);

        // Mispredict priority and squash; slot 0001 is rewritten while it issues.
        step(2'b11, 4'b0001, 4'b1000, 4'b0000, 4'b0010, 2'b00);
        step(2'b11, 4'b0001, 4'b0010, 4'b0000, 4'b0000, 2'b10);
        chk("prio pending", 32'(bus.pending_mask), 32'hb);
        chk("prio resolve", 32'(bus.b_mm_resolve), 32'h2);
        chk("prio mispred", 32'(bus.b_mm_mispred), 32'd1);
        step(2'b00, 4'b0, 4'b0, 4'b0, 4'b0, 2'b00);
        chk("prio squashed", 32'(bus.pending_mask), 32'h1);
        chk("prio next", 32'(bus.b_mm_resolve), 32'h1);
        chk("prio next mispred", 32'(bus.b_mm_mispred), 32'd0);
        step(2'b00, 4'b0, 4'b0, 4'b0, 4'b0, 2'b00);

        // Nested mispredicts.
        step(2'b11, 4'b0001, 4'b0100, 4'b0000, 4'b0001, 2'b11);
        chk("nested resolve", 32'(bus.b_mm_resolve), 32'h1);
        chk("nested mispred", 32'(bus.b_mm_mispred), 32'd1);
        step(2'b00, 4'b0, 4'b0, 4'b0, 4'b0, 2'b00);
        chk("nested count", 32'(bus.pending_count), 32'd0);

        // Incoming report squashed by the mispredict issuing in the same cycle.
        step(2'b01, 4'b0010, 4'b0000, 4'b0000, 4'b0000, 2'b01);
        chk("incoming issue", 32'(bus.b_mm_resolve), 32'h2);
        step(2'b01, 4'b1000, 4'b0000, 4'b0010, 4'b0000, 2'b00);
        chk("incoming dropped", 32'(bus.pending_mask[3]), 32'd0);

        // Asynchronous reset between clock edges.
        step(2'b11, 4'b0001, 4'b0010, 4'b0000, 4'b0000, 2'b00);
        step(2'b11, 4'b0100, 4'b1000, 4'b0000, 4'b0000, 2'b00);
        chk("pre-reset pending", 32'(bus.pending_mask), 32'he);
        #2 reset = 1'b0;
        #1;
        chk("async pending", 32'(bus.pending_mask), 32'd0);
        chk("async resolve", 32'(bus.b_mm_resolve), 32'd0);
        chk("async count", 32'(bus.pending_count), 32'd0);
        model_clear();
        @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        repeat (3) step(2'b00, 4'b0, 4'b0, 4'b0, 4'b0, 2'b00);

        repeat (3000) random_step();
        repeat (6) step(2'b00, 4'b0, 4'b0, 4'b0, 4'b0, 2'b00);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/branch_resolve_queue.md
Name: branch_resolve_queue

Overview:
- Sits between the complete stage and the branch stack; it is the sole driver of the branch stack's b_mm_resolve / b_mm_mispred inputs.
- Accepts up to NUM_BR_UNITS branch resolution reports per cycle, buffers them in one slot per branch-mask bit, and releases exactly one resolution per cycle.
- Mispredictions go first, oldest first. Reports belonging to squashed younger branches are discarded, and resolved bits are scrubbed from every buffered dependency mask.

Parameters:
- B_MASK_WIDTH, 4, number of in-flight branches; one-hot mask width (matches the branch stack).
- NUM_BR_UNITS, 2, branch-capable execute units reporting per cycle.

Ports:
- clock  in  1  system clock.
- reset  in  1  asynchronous, active-low reset (asserted when 0).
- br_valid  in  NUM_BR_UNITS  report valid, per unit.
- br_b_mm  in  NUM_BR_UNITS x B_MASK_WIDTH  one-hot mask bit owned by the reporting branch.
- br_b_mask  in  NUM_BR_UNITS x B_MASK_WIDTH  mask of older unresolved branches this branch depends on.
- br_mispred  in  NUM_BR_UNITS  1 = mispredicted.
- b_mm_resolve  out  B_MASK_WIDTH  one-hot branch resolved this cycle; 0 = none.
- b_mm_mispred  out  1  the resolved branch was mispredicted; only meaningful when b_mm_resolve != 0.
- pending_mask  out  B_MASK_WIDTH  slots currently holding a report (debug/SVA).
- pending_count  out  $clog2(B_MASK_WIDTH)+1  population count of pending_mask.

Behaviour:
- Storage per slot i: valid[i], mispred[i], dep[i] (B_MASK_WIDTH bits). A slot is indexed by the position of the br_b_mm bit.
- Reset (reset==0, async): all valid, mispred and dep bits cleared. Outputs read b_mm_resolve=0, b_mm_mispred=0, pending_mask=0, pending_count=0.
- Output is combinational from registered slots only. Report-to-b_mm_resolve latency is exactly 1 cycle minimum. There is no same-cycle bypass.
- Selection each cycle:
  - Candidate set M = valid & mispred slots whose dep has no bit in (valid & mispred). This set is the oldest mispredicts.
  - If M is nonempty: issue the lowest index in M with b_mm_mispred=1.
  - Else if any valid slot exists: issue the lowest-index valid slot with b_mm_mispred=0.
  - Else: issue nothing (b_mm_resolve=0).
- On issue of bit s (next-edge update):
  - Clear valid[s].
  - Clear bit s from every dep[j].
  - If mispredicted, also clear valid[j] for every j with dep[j][s]=1, since those branches are squashed.
- Incoming reports in the same cycle get the same filter:
  - Dropped if the issue is a mispredict and br_b_mask has bit s.
  - Otherwise written with bit s removed from the stored dep.
- Multiple incoming reports in one cycle write independent slots. Two valid reports with the same br_b_mm is illegal; SVA fires.
- Writing a slot that is already valid and not being issued this cycle is illegal (SVA). No full condition exists, because there is one slot per mask bit.
- Writing to slot s in the same cycle slot s is issued is legal: the write wins, because the branch stack recycles the bit.
- A non-one-hot br_b_mm with br_valid=1 is illegal (SVA). A report with br_b_mask containing its own br_b_mm bit is illegal (SVA).
- Reset asserted mid-operation discards all pending reports immediately (async). The output goes to 0 in the same cycle.

Decomposition:
- Shared package (sys_defs): B_MASK_WIDTH, the B_MASK typedef, and a BR_RESOLVE_PACKET typedef {valid, b_mm, b_mask, mispred} reused by the complete stage.
- One sub-module: br_resolve_select. It is purely combinational: given valid/mispred/dep it returns the one-hot issue mask and the mispred flag. This lets it be unit-tested in isolation.
- Slot storage, scrubbing and write logic stay in the top module.

Test Plan:
- Single correct branch: slot 0100, b_mask 0000, mispred=0 at cycle t -> at t+1 b_mm_resolve=0100, b_mm_mispred=0; at t+2 b_mm_resolve=0000, pending_count=0.
- Two simultaneous correct reports:
  - Stimulus: 0001 and 0100 at cycle t.
  - Required: t+1 issues 0001; t+2 issues 0100. Slot 0100's dep is scrubbed of 0001 at t+1.
- Mispredict priority and squash:
  - Pending state: 0001 correct; 0010 mispred with dep 0000; 1000 correct with dep 0010.
  - Required: 0010 issues first with mispred=1; 1000 is removed (pending_mask=0001); next cycle 0001 issues with mispred=0.
- Nested mispredicts:
  - Stimulus: 0001 mispred with dep 0000 and 0100 mispred with dep 0001, same cycle.
  - Required: only 0001 issues, mispred=1; 0100 is squashed; pending_count=0 afterwards.
- Squash of an incoming report: while slot 0010 issues as mispred, a new report 1000 with b_mask 0010 arrives -> it is not written; pending_mask bit 3 stays 0.
- Async reset mid-operation: three pending slots, reset driven 0 between clock edges -> pending_mask=0 and b_mm_resolve=0 immediately; after release, nothing issues until new reports arrive.
